fb_reader: RTL and testbench

//   Pixel source directly upstream of the VGA timing controller. Takes its pixel request

---
 rtl/fb_reader_pkg.sv | 22 ++
 rtl/fb_addr_gen.sv | 42 ++++
 rtl/fb_reader.sv | 106 ++++++++++
 tb/tb_fb_reader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_reader_pkg.sv
// Shared VGA definitions: active resolution, the "no request" coordinate code,
// RGB444 pixel width and the swap FSM state type. The timing controller imports
// the same constants so both ends agree on frame geometry.
package fb_reader_pkg;

  localparam int          VGA_H_RES = 640;
  localparam int          VGA_V_RES = 480;
  localparam int          COORD_W   = 10;
  localparam int          RGB_W     = 12;
  localparam logic [9:0]  NO_REQ    = 10'h3FF;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  // A coordinate pair is a request only when neither axis carries the NO_REQ code.
  function automatic logic coord_req(input logic [9:0] x, input logic [9:0] y);
    return (x != NO_REQ) && (y != NO_REQ);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Purpose: pure combinational map from pixel coordinate + bank to framebuffer address.
// Ports:   pix_x/pix_y in (10b), bank in; addr out (AW), in_range out (valid in-frame request).
// Address = bank*FB_W*FB_H + (pix_y>>SCALE_SHIFT)*FB_W + (pix_x>>SCALE_SHIFT), all at AW bits.
module fb_addr_gen
  import fb_reader_pkg::*;
#(
  parameter int H_RES       = VGA_H_RES,
  parameter int V_RES       = VGA_V_RES,
  parameter int SCALE_SHIFT = 2,
  parameter int AW          = 16
) (
  input  logic [9:0]    pix_x,
  input  logic [9:0]    pix_y,
  input  logic          bank,
  output logic [AW-1:0] addr,
  output logic          in_range
);

  localparam int FB_W = H_RES >> SCALE_SHIFT;
  localparam int FB_H = V_RES >> SCALE_SHIFT;

  // Both banks must fit: 2*FB_W*FB_H <= 2**AW.
  localparam logic [AW-1:0] FB_W_A    = AW'(FB_W);
  localparam logic [AW-1:0] BANK_BASE = AW'(FB_W * FB_H);

  logic [AW-1:0] col;
  logic [AW-1:0] row;
  logic [AW-1:0] base;

  // Widen before the multiply so no partial product is truncated.
  assign col  = AW'(pix_x >> SCALE_SHIFT);
  assign row  = AW'(pix_y >> SCALE_SHIFT);
  assign base = bank ? BANK_BASE : '0;
  assign addr = base + (row * FB_W_A) + col;

  // Out-of-range coordinates are demoted to "no request" so an aliased BRAM word
  // never reaches the screen.
  assign in_range = coord_req(pix_x, pix_y)
                  && (pix_x < 10'(H_RES))
                  && (pix_y < 10'(V_RES));

endmodule

// File: rtl/fb_reader.sv
// Purpose: double-buffered, upscaled framebuffer pixel source for the VGA timing controller;
//          bank flips only at frame end via a swap_req/swap_ack handshake.
// Ports:   clk/rstn; pix_x/pix_y request in; pixel out (1 clk later); rd_addr/rd_data to
//          synchronous BRAM; swap_req in, swap_ack/disp_bank/frame_end out.
module fb_reader
  import fb_reader_pkg::*;
#(
  parameter int         H_RES       = VGA_H_RES,
  parameter int         V_RES       = VGA_V_RES,
  parameter int         SCALE_SHIFT = 2,
  parameter int         AW          = 16,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [9:0]    pix_x,
  input  logic [9:0]    pix_y,
  output logic [11:0]   pixel,
  output logic [AW-1:0] rd_addr,
  input  logic [11:0]   rd_data,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          disp_bank,
  output logic          frame_end
);

  logic        req;
  logic        last;

  logic        req_q,       req_d;
  logic        frame_end_q, frame_end_d;
  logic        swap_ack_q,  swap_ack_d;
  logic        disp_bank_q, disp_bank_d;
  swap_state_e state_q,     state_d;

  fb_addr_gen #(
    .H_RES       (H_RES),
    .V_RES       (V_RES),
    .SCALE_SHIFT (SCALE_SHIFT),
    .AW          (AW)
  ) u_addr_gen (
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .bank     (disp_bank_q),
    .addr     (rd_addr),
    .in_range (req)
  );

  assign last = req && (pix_x == 10'(H_RES - 1)) && (pix_y == 10'(V_RES - 1));

  // BRAM read latency is the whole pipeline: req_q simply tracks which rd_data is real.
  assign req_d       = req;
  assign frame_end_d = last;

  // The flip is registered on the same edge that launches the last pixel's read, so that
  // pixel was addressed with the old bank and the next frame is entirely the new one.
  always_comb begin
    state_d     = state_q;
    disp_bank_d = disp_bank_q;
    swap_ack_d  = 1'b0;
    unique case (state_q)
      SWAP_IDLE: begin
        if (swap_req) begin
          if (last) begin
            disp_bank_d = ~disp_bank_q;
            swap_ack_d  = 1'b1;
          end else begin
            state_d = SWAP_PENDING;
          end
        end
      end
      SWAP_PENDING: begin
        if (!swap_req) begin
          state_d = SWAP_IDLE;          // request withdrawn, no flip
        end else if (last) begin
          disp_bank_d = ~disp_bank_q;
          swap_ack_d  = 1'b1;
          state_d     = SWAP_IDLE;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q       <= 1'b0;
      frame_end_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      disp_bank_q <= 1'b0;
      state_q     <= SWAP_IDLE;
    end else begin
      req_q       <= req_d;
      frame_end_q <= frame_end_d;
      swap_ack_q  <= swap_ack_d;
      disp_bank_q <= disp_bank_d;
      state_q     <= state_d;
    end
  end

  assign pixel     = req_q ? rd_data : BG_COLOR;
  assign swap_ack  = swap_ack_q;
  assign disp_bank = disp_bank_q;
  assign frame_end = frame_end_q;

endmodule

// File: tb/tb_fb_reader.sv
module tb_fb_reader;

  localparam logic [9:0] NO = 10'h3FF;

  logic        clk;
  logic        rstn;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pixel;
  logic [15:0] rd_addr;
  logic [11:0] rd_data;
  logic        swap_req, swap_ack, disp_bank, frame_end;

  // Small-geometry instance for full-frame runs (32x16 active, 40x21 total, 8x4 framebuffer).
  logic [9:0]  s_pix_x, s_pix_y;
  logic [11:0] s_pixel;
  logic [15:0] s_rd_addr;
  logic [11:0] s_rd_data;
  logic        s_swap_req, s_swap_ack, s_disp_bank, s_frame_end;

  logic [11:0] mem_a [0:65535];
  logic [11:0] mem_b [0:65535];

  int total;
  int bad;

  fb_reader #(
    .H_RES(640), .V_RES(480), .SCALE_SHIFT(2), .AW(16), .BG_COLOR(12'h000)
  ) dut (
    .clk(clk), .rstn(rstn), .pix_x(pix_x), .pix_y(pix_y), .pixel(pixel),
    .rd_addr(rd_addr), .rd_data(rd_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .disp_bank(disp_bank), .frame_end(frame_end)
  );

  fb_reader #(
    .H_RES(32), .V_RES(16), .SCALE_SHIFT(2), .AW(16), .BG_COLOR(12'h000)
  ) dut_s (
    .clk(clk), .rstn(rstn), .pix_x(s_pix_x), .pix_y(s_pix_y), .pixel(s_pixel),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data), .swap_req(s_swap_req), .swap_ack(s_swap_ack),
    .disp_bank(s_disp_bank), .frame_end(s_frame_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read BRAM models.
  always @(posedge clk) begin
    rd_data   <= mem_a[rd_addr];
    s_rd_data <= mem_b[s_rd_addr];
  end

  function automatic logic [11:0] pat(input int a);
    return 12'((a * 37 + 5) & 32'hFFF);
  endfunction

  function automatic logic [11:0] pat2(input int a);
    return 12'((a * 3 + 1) & 32'hFFF);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          fe_cnt;
    int          mbank;
    logic        act;
    logic [11:0] exp_px;

    total = 0;
    bad   = 0;
    rstn = 1'b0; pix_x = 10'd5; pix_y = 10'd5; swap_req = 1'b0;
    s_pix_x = NO; s_pix_y = NO; s_swap_req = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = pat(i);
      mem_b[i] = pat2(i);
    end
    mem_a[162]   = 12'hABC;
    mem_a[41055] = 12'hFFF;   // address of (3FF,3FF) in bank 0
    mem_a[495]   = 12'hFFF;   // aliased address of (700,10)

    // 1: reset
    step(); step();
    chk("rst_pixel", pixel, 12'h000);
    chk("rst_bank", disp_bank, 0);
    chk("rst_ack", swap_ack, 0);
    chk("rst_frame_end", frame_end, 0);
    rstn = 1'b1;
    #1 chk("rel_first_bg", pixel, 12'h000);
    step();
    chk("rel_pixel_5_5", pixel, pat(161));

    // 2: address and latency
    pix_x = 10'd8; pix_y = 10'd4;
    #1 chk("addr_8_4", rd_addr, 162);
    step();
    chk("lat_8_4", pixel, 12'hABC);

    // 3: blank and out of range
    pix_x = NO; pix_y = NO;
    step();
    chk("blank_rd_data", rd_data, 12'hFFF);
    chk("blank_pixel", pixel, 12'h000);
    pix_x = 10'd700; pix_y = 10'd10;
    step();
    chk("oor_rd_data", rd_data, 12'hFFF);
    chk("oor_pixel", pixel, 12'h000);

    // 4: swap held until frame end
    swap_req = 1'b1; pix_x = 10'd100; pix_y = 10'd100;
    step();
    chk("pend_bank", disp_bank, 0);
    chk("pend_ack", swap_ack, 0);
    pix_x = 10'd101;
    step();
    chk("pend_bank2", disp_bank, 0);
    chk("pend_pixel", pixel, pat(4025));
    pix_x = 10'd639; pix_y = 10'd479;
    #1 chk("addr_last_b0", rd_addr, 19199);
    step();
    chk("swap_bank", disp_bank, 1);
    chk("swap_ack", swap_ack, 1);
    chk("swap_frame_end", frame_end, 1);
    chk("swap_last_px_old_bank", pixel, pat(19199));
    swap_req = 1'b0; pix_x = 10'd0; pix_y = 10'd0;
    #1 chk("addr_0_0_b1", rd_addr, 19200);
    step();
    chk("ack_pulse_end", swap_ack, 0);
    chk("fe_pulse_end", frame_end, 0);
    chk("bank_hold", disp_bank, 1);
    chk("px_0_0_b1", pixel, pat(19200));

    // mid-frame reset
    pix_x = 10'd20; pix_y = 10'd20; rstn = 1'b0;
    #1 chk("mrst_bank", disp_bank, 0);
    chk("mrst_pixel", pixel, 12'h000);
    chk("mrst_addr", rd_addr, 805);
    step();
    rstn = 1'b1;
    #1 chk("mrst_first_bg", pixel, 12'h000);
    step();
    chk("mrst_resume", pixel, pat(805));

    // 5: coincident swap request and last pixel
    swap_req = 1'b1; pix_x = 10'd639; pix_y = 10'd479;
    step();
    chk("coin_bank", disp_bank, 1);
    chk("coin_ack", swap_ack, 1);
    chk("coin_px", pixel, pat(19199));
    swap_req = 1'b0; pix_x = NO; pix_y = NO;
    step();
    chk("coin_ack_end", swap_ack, 0);
    chk("coin_blank", pixel, 12'h000);

    // withdrawn request
    swap_req = 1'b1; pix_x = 10'd10; pix_y = 10'd10;
    step();
    swap_req = 1'b0;
    step();
    pix_x = 10'd639; pix_y = 10'd479;
    #1 chk("addr_last_b1", rd_addr, 38399);
    step();
    chk("wd_bank", disp_bank, 1);
    chk("wd_ack", swap_ack, 0);
    chk("wd_frame_end", frame_end, 1);
    chk("wd_px", pixel, pat(38399));

    // request still high after ack counts as a new one
    swap_req = 1'b1;
    step();
    chk("renew_bank0", disp_bank, 0);
    chk("renew_ack0", swap_ack, 1);
    pix_x = NO; pix_y = NO;
    step();
    chk("renew_ack_gap", swap_ack, 0);
    pix_x = 10'd639; pix_y = 10'd479;
    step();
    chk("renew_bank1", disp_bank, 1);
    chk("renew_ack1", swap_ack, 1);
    swap_req = 1'b0; pix_x = NO; pix_y = NO;
    step();

    // 6: two full frames on the small instance, swap at end of the first
    mbank = 0;
    s_swap_req = 1'b1;
    for (int f = 0; f < 2; f++) begin
      fe_cnt = 0;
      for (int y = 0; y < 21; y++) begin
        for (int x = 0; x < 40; x++) begin
          act     = (x < 32) && (y < 16);
          s_pix_x = act ? 10'(x) : NO;
          s_pix_y = act ? 10'(y) : NO;
          exp_px  = act ? pat2(mbank * 32 + (y >> 2) * 8 + (x >> 2)) : 12'h000;
          step();
          chk("frame_px", s_pixel, exp_px);
          if (s_frame_end) fe_cnt++;
          if (f == 0 && x == 31 && y == 15) begin
            chk("frame_swap_ack", s_swap_ack, 1);
            s_swap_req = 1'b0;
            mbank = 1;
          end
        end
      end
      chk("frame_end_count", fe_cnt, 1);
      chk("frame_bank", s_disp_bank, mbank);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
